// File: rtl/tdp_ram36k_pkg.sv
// Shared constants and address/width helpers for the 36Kb true dual-port RAM.
// Storage is 4096 lanes of 9 bits (8 data + 1 parity).
package tdp_ram36k_pkg;

    localparam int unsigned LANES      = 4096;
    localparam int unsigned LANE_W     = 9;
    localparam int unsigned ADDR_W     = 15;
    localparam int unsigned LANE_IDX_W = 12;

    typedef logic [LANE_W-1:0]     lane_t;
    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    function automatic bit width_legal(int w);
        return (w == 9) || (w == 18) || (w == 36);
    endfunction

    function automatic int unsigned width_to_lanes(int w);
        case (w)
            36:      return 4;
            18:      return 2;
            default: return 1;
        endcase
    endfunction

    // Bit address is MSB-aligned: the lane index sits in ADDR[14:3], and wider
    // accesses simply clear the low lane-index bits.
    function automatic lane_idx_t lane_base(logic [ADDR_W-1:0] addr, int w);
        lane_idx_t idx;
        idx = LANE_IDX_W'(addr >> 3);
        return idx & ~LANE_IDX_W'(width_to_lanes(w) - 1);
    endfunction

endpackage

// File: rtl/tdp_ram36k_lane_map.sv
// Per-port address/width translation: lane base for writes and reads, packing of
// write data into lanes, and zero-padded unpacking of read lanes.
module tdp_ram36k_lane_map
    import tdp_ram36k_pkg::*;
#(
    parameter int WR_W = 36,
    parameter int RD_W = 36
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wparity,
    input  logic [3:0]        be,
    input  lane_t [3:0]       rd_lanes,
    output lane_idx_t         wr_base,
    output logic [3:0]        wr_en,
    output lane_t [3:0]       wr_lanes,
    output lane_idx_t         rd_base,
    output logic [31:0]       rdata,
    output logic [3:0]        rparity
);

    localparam int unsigned WR_N = width_to_lanes(WR_W);
    localparam int unsigned RD_N = width_to_lanes(RD_W);

    if (!width_legal(WR_W) || !width_legal(RD_W)) begin : g_bad_width
        $fatal(1, "tdp_ram36k_lane_map: port widths must be 9, 18 or 36");
    end

    assign wr_base = lane_base(addr, WR_W);
    assign rd_base = lane_base(addr, RD_W);

    always_comb begin
        wr_en    = '0;
        wr_lanes = '0;
        rdata    = '0;
        rparity  = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            wr_lanes[k] = {wparity[k], wdata[8*k +: 8]};
            if (k < WR_N) begin
                wr_en[k] = be[k];
            end
            if (k < RD_N) begin
                rdata[8*k +: 8] = rd_lanes[k][7:0];
                rparity[k]      = rd_lanes[k][8];
            end
        end
    end

endmodule

// File: rtl/tdp_ram36k_core.sv
// True dual-port 36Kb block RAM with independent clocks and 9/18/36-bit ports.
// Each port owns a bank; per-lane flag pairs record which bank wrote last.
module tdp_ram36k_core
    import tdp_ram36k_pkg::*;
#(
    parameter logic [LANES*8-1:0] INIT          = '0,
    parameter logic [LANES-1:0]   INIT_PARITY   = '0,
    parameter int                 WRITE_WIDTH_A = 36,
    parameter int                 READ_WIDTH_A  = 36,
    parameter int                 WRITE_WIDTH_B = 36,
    parameter int                 READ_WIDTH_B  = 36
) (
    input  logic              RESET,
    input  logic              WR_CLK,
    input  logic              CLK_B,
    input  logic              WEN_A,
    input  logic              WEN_B,
    input  logic              REN_A,
    input  logic              REN_B,
    input  logic [3:0]        BE_A,
    input  logic [3:0]        BE_B,
    input  logic [ADDR_W-1:0] ADDR_A,
    input  logic [ADDR_W-1:0] ADDR_B,
    input  logic [31:0]       WDATA_A,
    input  logic [31:0]       WDATA_B,
    input  logic [3:0]        WPARITY_A,
    input  logic [3:0]        WPARITY_B,
    output logic [31:0]       RDATA_A,
    output logic [31:0]       RDATA_B,
    output logic [3:0]        RPARITY_A,
    output logic [3:0]        RPARITY_B
);

    logic [LANES*8-1:0] data_a = INIT;
    logic [LANES-1:0]   par_a  = INIT_PARITY;
    logic [LANES*8-1:0] data_b;
    logic [LANES-1:0]   par_b;
    logic [LANES-1:0]   flag_a = '0;
    logic [LANES-1:0]   flag_b = '0;

    lane_idx_t   a_wr_base, a_rd_base, b_wr_base, b_rd_base;
    logic [3:0]  a_wr_en, b_wr_en, a_keep;
    lane_t [3:0] a_wr_lanes, b_wr_lanes, a_rd_lanes, b_rd_lanes;
    logic [31:0] a_rdata, b_rdata;
    logic [3:0]  a_rparity, b_rparity;

    tdp_ram36k_lane_map #(.WR_W(WRITE_WIDTH_A), .RD_W(READ_WIDTH_A)) u_map_a (
        .addr(ADDR_A), .wdata(WDATA_A), .wparity(WPARITY_A), .be(BE_A),
        .rd_lanes(a_rd_lanes), .wr_base(a_wr_base), .wr_en(a_wr_en),
        .wr_lanes(a_wr_lanes), .rd_base(a_rd_base), .rdata(a_rdata),
        .rparity(a_rparity)
    );

    tdp_ram36k_lane_map #(.WR_W(WRITE_WIDTH_B), .RD_W(READ_WIDTH_B)) u_map_b (
        .addr(ADDR_B), .wdata(WDATA_B), .wparity(WPARITY_B), .be(BE_B),
        .rd_lanes(b_rd_lanes), .wr_base(b_wr_base), .wr_en(b_wr_en),
        .wr_lanes(b_wr_lanes), .rd_base(b_rd_base), .rdata(b_rdata),
        .rparity(b_rparity)
    );

    // A lane holds bank A's value when the flags match, bank B's otherwise.
    always_comb begin
        lane_idx_t la;
        lane_idx_t lb;
        la = '0;
        lb = '0;
        a_rd_lanes = '0;
        b_rd_lanes = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            la = a_rd_base | LANE_IDX_W'(k);
            lb = b_rd_base | LANE_IDX_W'(k);
            a_rd_lanes[k] = (flag_a[la] == flag_b[la]) ? {par_a[la], data_a[{la, 3'b000} +: 8]}
                                                       : {par_b[la], data_b[{la, 3'b000} +: 8]};
            b_rd_lanes[k] = (flag_a[lb] == flag_b[lb]) ? {par_a[lb], data_a[{lb, 3'b000} +: 8]}
                                                       : {par_b[lb], data_b[{lb, 3'b000} +: 8]};
        end
    end

    // Port A yields any lane port B is writing on the same edge; only meaningful
    // when both ports share a clock, asynchronous collisions being undefined.
    always_comb begin
        a_keep = a_wr_en;
        for (int unsigned k = 0; k < 4; k++) begin
            for (int unsigned j = 0; j < 4; j++) begin
                if (WEN_B && b_wr_en[j] &&
                    ((b_wr_base | LANE_IDX_W'(j)) == (a_wr_base | LANE_IDX_W'(k)))) begin
                    a_keep[k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge WR_CLK) begin
        if (WEN_A && !RESET) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (a_keep[k]) begin
                    data_a[{a_wr_base | LANE_IDX_W'(k), 3'b000} +: 8] <= a_wr_lanes[k][7:0];
                    par_a[a_wr_base | LANE_IDX_W'(k)]  <= a_wr_lanes[k][8];
                    flag_a[a_wr_base | LANE_IDX_W'(k)] <= flag_b[a_wr_base | LANE_IDX_W'(k)];
                end
            end
        end
    end

    always_ff @(posedge CLK_B) begin
        if (WEN_B && !RESET) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (b_wr_en[k]) begin
                    data_b[{b_wr_base | LANE_IDX_W'(k), 3'b000} +: 8] <= b_wr_lanes[k][7:0];
                    par_b[b_wr_base | LANE_IDX_W'(k)]  <= b_wr_lanes[k][8];
                    flag_b[b_wr_base | LANE_IDX_W'(k)] <= ~flag_a[b_wr_base | LANE_IDX_W'(k)];
                end
            end
        end
    end

    always_ff @(posedge WR_CLK or posedge RESET) begin
        if (RESET) begin
            RDATA_A   <= '0;
            RPARITY_A <= '0;
        end else if (REN_A) begin
            RDATA_A   <= a_rdata;
            RPARITY_A <= a_rparity;
        end
    end

    always_ff @(posedge CLK_B or posedge RESET) begin
        if (RESET) begin
            RDATA_B   <= '0;
            RPARITY_B <= '0;
        end else if (REN_B) begin
            RDATA_B   <= b_rdata;
            RPARITY_B <= b_rparity;
        end
    end

endmodule

// File: tb/tb_tdp_ram36k_core.sv
// Directed scoreboard bench: dut0 is 36/36 on both ports, dut1 reads port B at
// width 9 and carries a non-zero INIT in lane 0. Both share stimulus and clock.
module tb_tdp_ram36k_core;

    localparam logic [32767:0] INIT1   = 32768'h3C;
    localparam logic [2047:0]  INITP1  = 2048'h1;

    logic        clk = 1'b0;
    logic        RESET;
    logic        WEN_A, WEN_B, REN_A, REN_B;
    logic [3:0]  BE_A, BE_B, WPARITY_A, WPARITY_B;
    logic [14:0] ADDR_A, ADDR_B;
    logic [31:0] WDATA_A, WDATA_B;
    logic [31:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
    logic [3:0]  rpar_a0, rpar_b0, rpar_a1, rpar_b1;

    typedef struct {
        string       tag;
        int          sel;
        logic [35:0] exp;
    } item_t;

    item_t q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    tdp_ram36k_core dut0 (
        .RESET(RESET), .WR_CLK(clk), .CLK_B(clk),
        .WEN_A(WEN_A), .WEN_B(WEN_B), .REN_A(REN_A), .REN_B(REN_B),
        .BE_A(BE_A), .BE_B(BE_B), .ADDR_A(ADDR_A), .ADDR_B(ADDR_B),
        .WDATA_A(WDATA_A), .WDATA_B(WDATA_B),
        .WPARITY_A(WPARITY_A), .WPARITY_B(WPARITY_B),
        .RDATA_A(rdata_a0), .RDATA_B(rdata_b0),
        .RPARITY_A(rpar_a0), .RPARITY_B(rpar_b0)
    );

    tdp_ram36k_core #(
        .INIT(INIT1), .INIT_PARITY(INITP1),
        .WRITE_WIDTH_A(36), .READ_WIDTH_A(36),
        .WRITE_WIDTH_B(36), .READ_WIDTH_B(9)
    ) dut1 (
        .RESET(RESET), .WR_CLK(clk), .CLK_B(clk),
        .WEN_A(WEN_A), .WEN_B(WEN_B), .REN_A(REN_A), .REN_B(REN_B),
        .BE_A(BE_A), .BE_B(BE_B), .ADDR_A(ADDR_A), .ADDR_B(ADDR_B),
        .WDATA_A(WDATA_A), .WDATA_B(WDATA_B),
        .WPARITY_A(WPARITY_A), .WPARITY_B(WPARITY_B),
        .RDATA_A(rdata_a1), .RDATA_B(rdata_b1),
        .RPARITY_A(rpar_a1), .RPARITY_B(rpar_b1)
    );

    // sel: 0 = dut0 A, 1 = dut0 B, 2 = dut1 A, 3 = dut1 B; value is {parity, data}.
    function automatic logic [35:0] obs(int sel);
        case (sel)
            0:       return {rpar_a0, rdata_a0};
            1:       return {rpar_b0, rdata_b0};
            2:       return {rpar_a1, rdata_a1};
            default: return {rpar_b1, rdata_b1};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [35:0] observed, input logic [35:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed {par,data}=%h expected %h", tag, observed, expected);
        end
    endtask

    task automatic expect_rd(input string tag, input int sel, input logic [31:0] d, input logic [3:0] p);
        item_t it;
        it.tag = tag;
        it.sel = sel;
        it.exp = {p, d};
        q.push_back(it);
    endtask

    task automatic tick();
        item_t it;
        @(posedge clk);
        #1;
        while (q.size() > 0) begin
            it = q.pop_front();
            chk(it.tag, obs(it.sel), it.exp);
        end
    endtask

    initial begin
        RESET = 1'b1;
        WEN_A = 1'b0; WEN_B = 1'b0; REN_A = 1'b0; REN_B = 1'b0;
        BE_A = 4'h0; BE_B = 4'h0; WPARITY_A = 4'h0; WPARITY_B = 4'h0;
        ADDR_A = '0; ADDR_B = '0; WDATA_A = '0; WDATA_B = '0;
        tick();
        tick();
        chk("reset_a0", obs(0), 36'h0);
        chk("reset_b0", obs(1), 36'h0);
        chk("reset_b1", obs(3), 36'h0);
        RESET = 1'b0;
        tick();

        // INIT contents and output hold while REN is low
        REN_B = 1'b1; ADDR_B = 15'h0000;
        expect_rd("init_b1_w9", 3, 32'h0000003C, 4'h1);
        expect_rd("init_b0_w36", 1, 32'h0, 4'h0);
        tick();
        REN_B = 1'b0; ADDR_B = 15'h0028;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_b1", obs(3), {4'h1, 32'h0000003C});
        end

        // Full-word write on A, read back through B
        WEN_A = 1'b1; ADDR_A = 15'h0020; WDATA_A = 32'hDEADBEEF; WPARITY_A = 4'hA; BE_A = 4'hF;
        tick();
        WEN_A = 1'b0;
        REN_B = 1'b1; ADDR_B = 15'h0020;
        expect_rd("wr36_rd_b0", 1, 32'hDEADBEEF, 4'hA);
        expect_rd("wr36_rd_b1_lane4", 3, 32'h000000EF, 4'h0);
        tick();

        // Mixed aspect: lane 5 through the width-9 port
        ADDR_B = 15'h0028;
        expect_rd("mixed_b1_lane5", 3, 32'h000000BE, 4'h1);
        expect_rd("mixed_b0_word1", 1, 32'hDEADBEEF, 4'hA);
        tick();
        REN_B = 1'b0;

        // Byte enables 0101: lanes 0 and 2 updated
        WEN_A = 1'b1; BE_A = 4'b0101; WDATA_A = 32'h11223344; WPARITY_A = 4'h5;
        tick();
        WEN_A = 1'b0;
        REN_A = 1'b1; REN_B = 1'b1; ADDR_B = 15'h0020;
        expect_rd("be_a0", 0, 32'hDE22BE44, 4'hF);
        expect_rd("be_b0", 1, 32'hDE22BE44, 4'hF);
        expect_rd("be_a1", 2, 32'hDE22BE44, 4'hF);
        expect_rd("be_b1_lane4", 3, 32'h00000044, 4'h1);
        tick();
        REN_A = 1'b0;

        // Read-first collision: A writes word 0 while B reads it on the same edge
        WEN_A = 1'b1; ADDR_A = 15'h0000; WDATA_A = 32'h5555AAAA; WPARITY_A = 4'h0; BE_A = 4'hF;
        ADDR_B = 15'h0000;
        expect_rd("coll_old_b0", 1, 32'h0, 4'h0);
        expect_rd("coll_old_b1", 3, 32'h0000003C, 4'h1);
        tick();
        WEN_A = 1'b0;
        expect_rd("coll_new_b0", 1, 32'h5555AAAA, 4'h0);
        expect_rd("coll_new_b1", 3, 32'h000000AA, 4'h0);
        tick();
        REN_B = 1'b0;

        // Two writes to the same lanes on the same edge: B wins
        WEN_A = 1'b1; ADDR_A = 15'h0040; WDATA_A = 32'h11111111; WPARITY_A = 4'h1; BE_A = 4'hF;
        WEN_B = 1'b1; ADDR_B = 15'h0040; WDATA_B = 32'h22222222; WPARITY_B = 4'h2; BE_B = 4'hF;
        tick();
        WEN_A = 1'b0; WEN_B = 1'b0;
        REN_A = 1'b1;
        expect_rd("bwins_a0", 0, 32'h22222222, 4'h2);
        expect_rd("bwins_a1", 2, 32'h22222222, 4'h2);
        tick();
        REN_A = 1'b0;

        // Reset between edges clears outputs immediately and blocks writes
        #3;
        RESET = 1'b1;
        #1;
        chk("rst_async_a0", obs(0), 36'h0);
        chk("rst_async_b0", obs(1), 36'h0);
        chk("rst_async_b1", obs(3), 36'h0);
        WEN_A = 1'b1; ADDR_A = 15'h0000; WDATA_A = 32'hFFFFFFFF; WPARITY_A = 4'hF; BE_A = 4'hF;
        REN_B = 1'b1; ADDR_B = 15'h0000;
        tick();
        chk("rst_hold_b0", obs(1), 36'h0);
        RESET = 1'b0; WEN_A = 1'b0;
        expect_rd("rst_retain_b0", 1, 32'h5555AAAA, 4'h0);
        expect_rd("rst_retain_b1", 3, 32'h000000AA, 4'h0);
        tick();
        REN_B = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
